// File: rtl/frame_maker_pkg.sv
// frame_maker_pkg
//   Shared definitions for the CAN error/overload frame generator:
//   the sequencer state encoding and the default bit-length constants.
package frame_maker_pkg;

    localparam int FLAG_LEN_DEF   = 6;  // dominant bits in an error/overload flag
    localparam int DELIM_LEN_DEF  = 8;  // recessive bits in a delimiter
    localparam int INTERM_LEN_DEF = 3;  // recessive bits of intermission
    localparam int CNT_W_DEF      = 4;  // bit-counter width, must hold DELIM_LEN

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        ERR_FLAG  = 3'd1,
        ERR_WAIT  = 3'd2,
        ERR_DELIM = 3'd3,
        OVL_FLAG  = 3'd4,
        OVL_WAIT  = 3'd5,
        OVL_DELIM = 3'd6,
        INTERM    = 3'd7
    } frame_state_t;

endpackage

// File: rtl/frame_bit_counter.sv
// frame_bit_counter
//   Bit counter used by the frame sequencer to time flags, delimiters and
//   intermission. Clear wins over enable; atLimit compares against a limit
//   chosen by the sequencer for the current state.
// Ports
//   clk      in   bit-time clock (sample point)
//   reset    in   synchronous, active-high
//   clear    in   load 0 on the next edge
//   enable   in   increment on the next edge
//   limit    in   terminal value for the compare
//   atLimit  out  count == limit (combinational)
module frame_bit_counter #(
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             enable,
    input  logic [CNT_W-1:0] limit,
    output logic             atLimit
);

    logic [CNT_W-1:0] count;

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            count <= '0;
        end else if (enable) begin
            count <= count + 1'b1;
        end
    end

    assign atLimit = (count == limit);

endmodule

// File: rtl/frame_maker_top.sv
// frame_maker_top
//   CAN error/overload frame generator. Advances one step per bit-time
//   sample point, sequencing error frames (flag, wait, delimiter), overload
//   frames and intermission, and reporting SOF / completed overload frames.
// Ports
//   samplePoint  in   clock, one rising edge per CAN bit sample point
//   reset        in   synchronous, active-high
//   canRX        in   sampled bus level (0 = dominant)
//   frameReady   in   EOF of a data/remote frame just received (used in IDLE)
//   isError      in   request an error frame
//   endOverload  out  1-cycle pulse after the last overload delimiter bit
//   isStart      out  1-cycle pulse on an accepted SOF
//   canTX        out  bit to drive, dominant only during flags
//   debugState   out  current sequencer state
// Handshake: none; every input is a level sampled at each samplePoint edge.
module frame_maker_top
    import frame_maker_pkg::*;
#(
    parameter int FLAG_LEN   = FLAG_LEN_DEF,
    parameter int DELIM_LEN  = DELIM_LEN_DEF,
    parameter int INTERM_LEN = INTERM_LEN_DEF,
    parameter int CNT_W      = CNT_W_DEF
) (
    input  logic       samplePoint,
    input  logic       reset,
    input  logic       canRX,
    input  logic       frameReady,
    input  logic       isError,
    output logic       endOverload,
    output logic       isStart,
    output logic       canTX,
    output logic [2:0] debugState
);

    frame_state_t     state;
    logic             atLimit;
    logic             cntClear;
    logic             cntEnable;
    logic [CNT_W-1:0] cntLimit;
    logic             errAccept;

    // isError is honoured everywhere except inside an error frame, so a
    // held-high request cannot keep restarting the frame it triggered.
    assign errAccept = isError &&
                       (state != ERR_FLAG) && (state != ERR_WAIT) && (state != ERR_DELIM);

    always_comb begin
        cntLimit = '0;
        case (state)
            ERR_FLAG, OVL_FLAG:   cntLimit = CNT_W'(FLAG_LEN - 1);
            ERR_DELIM, OVL_DELIM: cntLimit = CNT_W'(DELIM_LEN - 1);
            INTERM:               cntLimit = CNT_W'(INTERM_LEN - 1);
            default:              cntLimit = '0;
        endcase
    end

    // Counter control mirrors the transitions below: the counter is cleared
    // on every state change. In *_WAIT it sits at 0, so the first recessive
    // bit increments it to 1 and that bit counts as delimiter bit 1.
    always_comb begin
        cntClear  = 1'b1;
        cntEnable = 1'b0;
        if (!errAccept) begin
            case (state)
                ERR_FLAG, OVL_FLAG: begin
                    cntEnable = !atLimit;
                    cntClear  = atLimit;
                end
                ERR_WAIT, OVL_WAIT: begin
                    cntEnable = canRX;
                    cntClear  = 1'b0;
                end
                ERR_DELIM, OVL_DELIM, INTERM: begin
                    cntEnable = canRX && !atLimit;
                    cntClear  = !(canRX && !atLimit);
                end
                default: begin
                    cntEnable = 1'b0;
                    cntClear  = 1'b1;
                end
            endcase
        end
    end

    frame_bit_counter #(.CNT_W(CNT_W)) bitCounter (
        .clk     (samplePoint),
        .reset   (reset),
        .clear   (cntClear),
        .enable  (cntEnable),
        .limit   (cntLimit),
        .atLimit (atLimit)
    );

    always_ff @(posedge samplePoint) begin
        if (reset) begin
            state       <= IDLE;
            endOverload <= 1'b0;
            isStart     <= 1'b0;
        end else begin
            endOverload <= 1'b0;
            isStart     <= 1'b0;
            if (errAccept) begin
                state <= ERR_FLAG;
            end else begin
                case (state)
                    IDLE: begin
                        if (frameReady) begin
                            state <= INTERM;
                        end else if (!canRX) begin
                            isStart <= 1'b1;
                        end
                    end
                    ERR_FLAG:  if (atLimit) state <= ERR_WAIT;
                    OVL_FLAG:  if (atLimit) state <= OVL_WAIT;
                    ERR_WAIT:  if (canRX) state <= ERR_DELIM;
                    OVL_WAIT:  if (canRX) state <= OVL_DELIM;
                    ERR_DELIM: begin
                        if (!canRX) begin
                            state <= ERR_FLAG;
                        end else if (atLimit) begin
                            state <= INTERM;
                        end
                    end
                    OVL_DELIM: begin
                        if (!canRX) begin
                            state <= ERR_FLAG;
                        end else if (atLimit) begin
                            state       <= INTERM;
                            endOverload <= 1'b1;
                        end
                    end
                    INTERM: begin
                        if (!canRX) begin
                            // Dominant on the last intermission bit is a SOF;
                            // earlier it is an overload condition.
                            if (atLimit) begin
                                isStart <= 1'b1;
                                state   <= IDLE;
                            end else begin
                                state <= OVL_FLAG;
                            end
                        end else if (atLimit) begin
                            state <= IDLE;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

    assign canTX      = !((state == ERR_FLAG) || (state == OVL_FLAG));
    assign debugState = state;

endmodule

// File: tb/tb_frame_maker_top.sv
module tb_frame_maker_top;

    localparam int FLAG_LEN   = 6;
    localparam int DELIM_LEN  = 8;
    localparam int INTERM_LEN = 3;

    // Reference model phases (frame-level view, counts completed bits)
    localparam int PH_IDLE   = 0;
    localparam int PH_FLAG   = 1;
    localparam int PH_WAIT   = 2;
    localparam int PH_DELIM  = 3;
    localparam int PH_INTERM = 4;

    logic       samplePoint;
    logic       reset;
    logic       canRX;
    logic       frameReady;
    logic       isError;
    logic       endOverload;
    logic       isStart;
    logic       canTX;
    logic [2:0] debugState;

    int checks = 0;
    int errors = 0;

    int   mPhase;
    bit   mOvl;
    int   mBit;
    logic expTx, expEnd, expStart;

    frame_maker_top dut (
        .samplePoint (samplePoint),
        .reset       (reset),
        .canRX       (canRX),
        .frameReady  (frameReady),
        .isError     (isError),
        .endOverload (endOverload),
        .isStart     (isStart),
        .canTX       (canTX),
        .debugState  (debugState)
    );

    // clock / reset defaults
    initial begin
        samplePoint = 1'b0;
        forever #5 samplePoint = ~samplePoint;
    end

    // Behavioural model: one call per bit, expressed as frame phases and
    // the number of bits already spent in each phase.
    task automatic model_step(input logic r, input logic e, input logic f, input logic x);
        expEnd   = 1'b0;
        expStart = 1'b0;
        if (r) begin
            mPhase = PH_IDLE;
            mBit   = 0;
            mOvl   = 1'b0;
        end else if (e && !(mPhase inside {PH_FLAG, PH_WAIT, PH_DELIM} && !mOvl)) begin
            mPhase = PH_FLAG;
            mOvl   = 1'b0;
            mBit   = 0;
        end else begin
            case (mPhase)
                PH_IDLE: begin
                    if (f) begin
                        mPhase = PH_INTERM;
                        mBit   = 0;
                    end else if (!x) begin
                        expStart = 1'b1;
                    end
                end
                PH_FLAG: begin
                    mBit++;
                    if (mBit == FLAG_LEN) mPhase = PH_WAIT;
                end
                PH_WAIT: begin
                    if (x) begin
                        mPhase = PH_DELIM;
                        mBit   = 1;
                    end
                end
                PH_DELIM: begin
                    if (!x) begin
                        mPhase = PH_FLAG;
                        mOvl   = 1'b0;
                        mBit   = 0;
                    end else begin
                        mBit++;
                        if (mBit == DELIM_LEN) begin
                            expEnd = mOvl;
                            mPhase = PH_INTERM;
                            mBit   = 0;
                        end
                    end
                end
                default: begin
                    if (!x) begin
                        if (mBit == INTERM_LEN - 1) begin
                            expStart = 1'b1;
                            mPhase   = PH_IDLE;
                        end else begin
                            mPhase = PH_FLAG;
                            mOvl   = 1'b1;
                            mBit   = 0;
                        end
                    end else begin
                        mBit++;
                        if (mBit == INTERM_LEN) mPhase = PH_IDLE;
                    end
                end
            endcase
        end
        expTx = (mPhase != PH_FLAG);
    endtask

    // driver: apply one bit's inputs, clock it, update model, settle
    task automatic tick(input logic r, input logic e, input logic f, input logic x);
        reset      = r;
        isError    = e;
        frameReady = f;
        canRX      = x;
        @(posedge samplePoint);
        model_step(r, e, f, x);
        #1;
    endtask

    task automatic test_reset();
        for (int i = 0; i < 2; i++) tick(1'b1, 1'b1, 1'b1, 1'b0);
        checks++;
        if (canTX !== 1'b1) begin
            errors++;
            $display("FAIL reset_canTX got %b want 1", canTX);
        end
        checks++;
        if (endOverload !== 1'b0) begin
            errors++;
            $display("FAIL reset_endOverload got %b want 0", endOverload);
        end
        checks++;
        if (isStart !== 1'b0) begin
            errors++;
            $display("FAIL reset_isStart got %b want 0", isStart);
        end
    endtask

    task automatic test_error_recessive();
        logic [3:0] seq[$];
        int zeros = 0, ends = 0;
        seq = {};
        seq.push_back(4'b1001);
        for (int i = 0; i < 3; i++) seq.push_back(4'b0101);
        for (int i = 0; i < 15; i++) seq.push_back(4'b0001);
        seq.push_back(4'b0000);
        foreach (seq[k]) begin
            tick(seq[k][3], seq[k][2], seq[k][1], seq[k][0]);
            if (canTX === 1'b0) zeros++;
            if (endOverload === 1'b1) ends++;
            checks++;
            if ({canTX, endOverload, isStart} !== {expTx, expEnd, expStart}) begin
                errors++;
                $display("FAIL err_recessive bit %0d got %b want %b", k,
                         {canTX, endOverload, isStart}, {expTx, expEnd, expStart});
            end
        end
        checks++;
        if (zeros != FLAG_LEN) begin
            errors++;
            $display("FAIL err_recessive_flag_len got %0d want %0d", zeros, FLAG_LEN);
        end
        checks++;
        if (ends != 0) begin
            errors++;
            $display("FAIL err_recessive_endOverload got %0d want 0", ends);
        end
        checks++;
        if (isStart !== 1'b1) begin
            errors++;
            $display("FAIL err_recessive_back_to_idle got %b want 1", isStart);
        end
    endtask

    task automatic test_superposition();
        logic [3:0] seq[$];
        int zeros = 0;
        seq = {};
        seq.push_back(4'b1001);
        seq.push_back(4'b0101);
        for (int i = 0; i < FLAG_LEN; i++) seq.push_back({3'b000, 1'($urandom_range(0, 1))});
        for (int i = 0; i < 11; i++) seq.push_back(4'b0000);
        for (int i = 0; i < DELIM_LEN + INTERM_LEN; i++) seq.push_back(4'b0001);
        seq.push_back(4'b0000);
        foreach (seq[k]) begin
            tick(seq[k][3], seq[k][2], seq[k][1], seq[k][0]);
            if (canTX === 1'b0) zeros++;
            checks++;
            if ({canTX, endOverload, isStart} !== {expTx, expEnd, expStart}) begin
                errors++;
                $display("FAIL superposition bit %0d got %b want %b", k,
                         {canTX, endOverload, isStart}, {expTx, expEnd, expStart});
            end
        end
        checks++;
        if (zeros != FLAG_LEN) begin
            errors++;
            $display("FAIL superposition_flag_len got %0d want %0d", zeros, FLAG_LEN);
        end
        checks++;
        if (isStart !== 1'b1) begin
            errors++;
            $display("FAIL superposition_back_to_idle got %b want 1", isStart);
        end
    endtask

    task automatic test_overload();
        logic [3:0] seq[$];
        int zeros = 0, ends = 0, endIdx = -1;
        seq = {};
        seq.push_back(4'b1001);
        seq.push_back(4'b0011);
        seq.push_back(4'b0000);
        for (int i = 0; i < FLAG_LEN; i++) seq.push_back({3'b000, 1'($urandom_range(0, 1))});
        for (int i = 0; i < DELIM_LEN + INTERM_LEN; i++) seq.push_back(4'b0001);
        foreach (seq[k]) begin
            tick(seq[k][3], seq[k][2], seq[k][1], seq[k][0]);
            if (canTX === 1'b0) zeros++;
            if (endOverload === 1'b1) begin
                ends++;
                endIdx = k;
            end
            checks++;
            if ({canTX, endOverload, isStart} !== {expTx, expEnd, expStart}) begin
                errors++;
                $display("FAIL overload bit %0d got %b want %b", k,
                         {canTX, endOverload, isStart}, {expTx, expEnd, expStart});
            end
        end
        checks++;
        if (zeros != FLAG_LEN) begin
            errors++;
            $display("FAIL overload_flag_len got %0d want %0d", zeros, FLAG_LEN);
        end
        checks++;
        if (ends != 1) begin
            errors++;
            $display("FAIL overload_end_count got %0d want 1", ends);
        end
        // seq index: 0 reset, 1 frameReady, 2 dominant, 3..8 flag, 9 delim bit 1, 16 delim bit 8
        checks++;
        if (endIdx != 16) begin
            errors++;
            $display("FAIL overload_end_position got %0d want 16", endIdx);
        end
    endtask

    task automatic test_sof();
        logic [3:0] seq[$];
        int starts = 0, zeros = 0;
        seq = {};
        seq.push_back(4'b1001);
        seq.push_back(4'b0011);
        seq.push_back(4'b0001);
        seq.push_back(4'b0001);
        seq.push_back(4'b0000);
        seq.push_back(4'b0001);
        seq.push_back(4'b0000);
        foreach (seq[k]) begin
            tick(seq[k][3], seq[k][2], seq[k][1], seq[k][0]);
            if (isStart === 1'b1) starts++;
            if (canTX === 1'b0) zeros++;
            checks++;
            if ({canTX, endOverload, isStart} !== {expTx, expEnd, expStart}) begin
                errors++;
                $display("FAIL sof bit %0d got %b want %b", k,
                         {canTX, endOverload, isStart}, {expTx, expEnd, expStart});
            end
        end
        checks++;
        if (starts != 2 || zeros != 0) begin
            errors++;
            $display("FAIL sof_counts got starts=%0d zeros=%0d want starts=2 zeros=0", starts, zeros);
        end
    endtask

    task automatic test_bit_error();
        logic [3:0] seq[$];
        int zeros = 0;
        seq = {};
        seq.push_back(4'b1001);
        seq.push_back(4'b0101);
        for (int i = 0; i < FLAG_LEN; i++) seq.push_back({3'b000, 1'($urandom_range(0, 1))});
        for (int i = 0; i < 3; i++) seq.push_back(4'b0001);
        seq.push_back(4'b0000);
        for (int i = 0; i < FLAG_LEN; i++) seq.push_back({3'b010, 1'($urandom_range(0, 1))});
        for (int i = 0; i < DELIM_LEN + INTERM_LEN; i++) seq.push_back(4'b0001);
        foreach (seq[k]) begin
            tick(seq[k][3], seq[k][2], seq[k][1], seq[k][0]);
            if (canTX === 1'b0) zeros++;
            checks++;
            if ({canTX, endOverload, isStart} !== {expTx, expEnd, expStart}) begin
                errors++;
                $display("FAIL bit_error bit %0d got %b want %b", k,
                         {canTX, endOverload, isStart}, {expTx, expEnd, expStart});
            end
        end
        checks++;
        if (zeros != 2 * FLAG_LEN) begin
            errors++;
            $display("FAIL bit_error_flag_bits got %0d want %0d", zeros, 2 * FLAG_LEN);
        end
    endtask

    task automatic test_reset_mid_frame();
        tick(1'b1, 1'b0, 1'b0, 1'b1);
        tick(1'b0, 1'b0, 1'b1, 1'b1);
        tick(1'b0, 1'b0, 1'b0, 1'b0);
        tick(1'b0, 1'b0, 1'b0, 1'b0);
        tick(1'b0, 1'b0, 1'b0, 1'b0);
        checks++;
        if (canTX !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_in_flag got %b want 0", canTX);
        end
        tick(1'b1, 1'b0, 1'b0, 1'b0);
        checks++;
        if ({canTX, endOverload, isStart} !== 3'b100) begin
            errors++;
            $display("FAIL reset_mid_outputs got %b want 100", {canTX, endOverload, isStart});
        end
        tick(1'b0, 1'b0, 1'b0, 1'b0);
        checks++;
        if ({canTX, endOverload, isStart} !== 3'b101) begin
            errors++;
            $display("FAIL reset_mid_idle_sof got %b want 101", {canTX, endOverload, isStart});
        end
    endtask

    task automatic test_random();
        logic r, e, f, x;
        for (int i = 0; i < 1500; i++) begin
            r = ($urandom_range(0, 199) == 0);
            e = ($urandom_range(0, 29) == 0);
            f = ($urandom_range(0, 7) == 0);
            x = ($urandom_range(0, 4) != 0);
            tick(r, e, f, x);
            checks++;
            if ({canTX, endOverload, isStart} !== {expTx, expEnd, expStart}) begin
                errors++;
                $display("FAIL random cyc %0d in=%b%b%b%b got %b want %b", i, r, e, f, x,
                         {canTX, endOverload, isStart}, {expTx, expEnd, expStart});
            end
        end
    endtask

    initial begin
        reset      = 1'b1;
        isError    = 1'b0;
        frameReady = 1'b0;
        canRX      = 1'b1;
        mPhase     = PH_IDLE;
        mOvl       = 1'b0;
        mBit       = 0;
        expTx      = 1'b1;
        expEnd     = 1'b0;
        expStart   = 1'b0;
        test_reset();
        test_error_recessive();
        test_superposition();
        test_overload();
        test_sof();
        test_bit_error();
        test_reset_mid_frame();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
